restoring_div_core: RTL and testbench

- Sequential unsigned restoring divider with a start/busy/done handshake; produces one quotient bit per clock.
- Holds the remainder (A) and quotient/dividend (Q) as a left-shifting register pair, with divisor register M.
- Each iteration shifts the next dividend bit out of Q into A, does a trial subtraction, and shifts the quotient bit into Q's LSB.
- Sits between the operand source (ALU/CPU issue) and the result writeback.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_trial_sub.sv | 24 ++
 rtl/restoring_div_core.sv | 122 ++++++++++++
 tb/tb_restoring_div_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: state encoding, default
// operand width and the iteration counter width helper.
package div_pkg;

    // FSM encoding; 2'd3 is unused and steers back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 32;

    // Iteration counter width: must hold 0..WIDTH-1
    function automatic int cntWidth(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division step: trial subtraction of the divisor from the
// shifted partial remainder, producing the next remainder and quotient bit.
// Kept separate so a non-restoring variant can reuse the subtractor.
module div_trial_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] sh_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] aNext_o,
    output logic             qBit_o
);

    logic [WIDTH:0] diff;

    // Extra top bit acts as the borrow; a borrow means restore the old value
    always_comb begin
        diff    = {1'b0, sh_i} - {1'b0, m_i};
        qBit_o  = ~diff[WIDTH];
        aNext_o = diff[WIDTH] ? sh_i : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/restoring_div_core.sv
// Sequential unsigned restoring divider, one quotient bit per falling clock
// edge, with start/busy/done handshake and divide-by-zero detection.
module restoring_div_core
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = cntWidth(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               divByZero_q, divByZero_d;

    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   aNext;
    logic               qBit;

    // Next dividend bit moves from the top of Q into the bottom of A
    assign shifted = {a_q[WIDTH-2:0], q_q[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .sh_i    (shifted),
        .m_i     (m_q),
        .aNext_o (aNext),
        .qBit_o  (qBit)
    );

    // All state advances on the falling edge; reset wipes everything at once
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
        end
    end

    // Handshake FSM plus datapath update; results only change on entering DONE
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d         = '0;
                    q_d         = dividend;
                    m_d         = divisor;
                    count_d     = '0;
                    divByZero_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (m_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = q_q;
                    divByZero_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    a_d     = aNext;
                    q_d     = {q_q[WIDTH-2:0], qBit};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        quotient_d  = {q_q[WIDTH-2:0], qBit};
                        remainder_d = aNext;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign div_by_zero = divByZero_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

endmodule

// File: tb/tb_restoring_div_core.sv
// Directed self-checking bench for restoring_div_core (WIDTH = 32).
module tb_restoring_div_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int assertCount = 0;
    int failCount   = 0;

    restoring_div_core #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    // Falling edges at 10,20,...; the bench drives and samples on rising edges
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one division from IDLE at a rising edge; returns the number of
    // falling edges after the accepting one until done, or -1 on timeout,
    // plus how many in-flight cycles showed busy low
    task automatic runDiv(input logic [31:0] dd, input logic [31:0] dv,
                          output int edges, output int drops);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        edges = 0;
        drops = 0;
        if (busy !== 1'b1) drops++;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
            @(posedge clk);
            if (done !== 1'b1 && busy !== 1'b1) drops++;
        end
        if (done !== 1'b1) edges = -1;
    endtask

    task automatic toIdle();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        assertCount++; if (div_by_zero !== 1'b0) begin failCount++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
        assertCount++; if (quotient !== 32'd0) begin failCount++; $display("[TB] FAIL reset_quotient: got %h expected 0", quotient); end
        assertCount++; if (remainder !== 32'd0) begin failCount++; $display("[TB] FAIL reset_remainder: got %h expected 0", remainder); end
        @(posedge clk);
        reset = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_basic();
        int edges, drops;
        runDiv(32'd100, 32'd7, edges, drops);
        assertCount++; if (edges !== 32) begin failCount++; $display("[TB] FAIL basic_latency: got %0d edges expected 32", edges); end
        assertCount++; if (drops !== 0) begin failCount++; $display("[TB] FAIL basic_busy_gap: got %0d low cycles expected 0", drops); end
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy); end
        assertCount++; if (quotient !== 32'd14) begin failCount++; $display("[TB] FAIL basic_quotient: got %0d expected 14", quotient); end
        assertCount++; if (remainder !== 32'd2) begin failCount++; $display("[TB] FAIL basic_remainder: got %0d expected 2", remainder); end
        assertCount++; if (div_by_zero !== 1'b0) begin failCount++; $display("[TB] FAIL basic_dbz: got %b expected 0", div_by_zero); end
        toIdle();
        assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
        assertCount++; if (quotient !== 32'd14) begin failCount++; $display("[TB] FAIL basic_hold_quotient: got %0d expected 14", quotient); end
    endtask

    task automatic test_extremes();
        int edges, drops;
        runDiv(32'hFFFFFFFF, 32'd1, edges, drops);
        assertCount++; if (quotient !== 32'hFFFFFFFF) begin failCount++; $display("[TB] FAIL max_div1_quotient: got %h expected ffffffff", quotient); end
        assertCount++; if (remainder !== 32'd0) begin failCount++; $display("[TB] FAIL max_div1_remainder: got %h expected 0", remainder); end
        toIdle();
        runDiv(32'hFFFFFFFF, 32'hFFFFFFFF, edges, drops);
        assertCount++; if (quotient !== 32'd1) begin failCount++; $display("[TB] FAIL max_divmax_quotient: got %h expected 1", quotient); end
        assertCount++; if (remainder !== 32'd0) begin failCount++; $display("[TB] FAIL max_divmax_remainder: got %h expected 0", remainder); end
        toIdle();
    endtask

    task automatic test_small();
        int edges, drops;
        runDiv(32'd3, 32'd10, edges, drops);
        assertCount++; if (quotient !== 32'd0) begin failCount++; $display("[TB] FAIL small_quotient: got %0d expected 0", quotient); end
        assertCount++; if (remainder !== 32'd3) begin failCount++; $display("[TB] FAIL small_remainder: got %0d expected 3", remainder); end
        toIdle();
        runDiv(32'd0, 32'd5, edges, drops);
        assertCount++; if (quotient !== 32'd0) begin failCount++; $display("[TB] FAIL zero_num_quotient: got %0d expected 0", quotient); end
        assertCount++; if (remainder !== 32'd0) begin failCount++; $display("[TB] FAIL zero_num_remainder: got %0d expected 0", remainder); end
        toIdle();
    endtask

    task automatic test_div_zero();
        int edges, drops;
        runDiv(32'd5, 32'd0, edges, drops);
        assertCount++; if (edges !== 1) begin failCount++; $display("[TB] FAIL dbz_latency: got %0d edges expected 1", edges); end
        assertCount++; if (div_by_zero !== 1'b1) begin failCount++; $display("[TB] FAIL dbz_flag: got %b expected 1", div_by_zero); end
        assertCount++; if (quotient !== 32'hFFFFFFFF) begin failCount++; $display("[TB] FAIL dbz_quotient: got %h expected ffffffff", quotient); end
        assertCount++; if (remainder !== 32'd5) begin failCount++; $display("[TB] FAIL dbz_remainder: got %0d expected 5", remainder); end
        toIdle();
        assertCount++; if (div_by_zero !== 1'b1) begin failCount++; $display("[TB] FAIL dbz_hold_idle: got %b expected 1", div_by_zero); end
        dividend = 32'd9; divisor = 32'd2; start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        assertCount++; if (div_by_zero !== 1'b0) begin failCount++; $display("[TB] FAIL dbz_clear_on_load: got %b expected 0", div_by_zero); end
        assertCount++; if (quotient !== 32'hFFFFFFFF) begin failCount++; $display("[TB] FAIL hold_quotient_while_busy: got %h expected ffffffff", quotient); end
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk); edges++; @(posedge clk);
        end
        assertCount++; if (edges !== 32) begin failCount++; $display("[TB] FAIL after_dbz_latency: got %0d edges expected 32", edges); end
        assertCount++; if (quotient !== 32'd4) begin failCount++; $display("[TB] FAIL after_dbz_quotient: got %0d expected 4", quotient); end
        assertCount++; if (remainder !== 32'd1) begin failCount++; $display("[TB] FAIL after_dbz_remainder: got %0d expected 1", remainder); end
        toIdle();
    endtask

    task automatic test_ignore_start();
        int edges;
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); @(posedge clk);
        end
        dividend = 32'd7; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        edges = 10;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk); edges++; @(posedge clk);
        end
        assertCount++; if (edges !== 32) begin failCount++; $display("[TB] FAIL ignore_busy_latency: got %0d edges expected 32", edges); end
        assertCount++; if (quotient !== 32'd333) begin failCount++; $display("[TB] FAIL ignore_busy_quotient: got %0d expected 333", quotient); end
        assertCount++; if (remainder !== 32'd1) begin failCount++; $display("[TB] FAIL ignore_busy_remainder: got %0d expected 1", remainder); end
        dividend = 32'd20; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        assertCount++; if (busy !== 1'b0 || done !== 1'b0) begin failCount++; $display("[TB] FAIL ignore_done_start: got busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        assertCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL accept_in_idle: got busy=%b expected 1", busy); end
        assertCount++; if (quotient !== 32'd333) begin failCount++; $display("[TB] FAIL hold_333_while_busy: got %0d expected 333", quotient); end
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk); edges++; @(posedge clk);
        end
        assertCount++; if (edges !== 32) begin failCount++; $display("[TB] FAIL held_start_latency: got %0d edges expected 32", edges); end
        assertCount++; if (quotient !== 32'd6) begin failCount++; $display("[TB] FAIL held_start_quotient: got %0d expected 6", quotient); end
        assertCount++; if (remainder !== 32'd2) begin failCount++; $display("[TB] FAIL held_start_remainder: got %0d expected 2", remainder); end
        toIdle();
    endtask

    task automatic test_reset_midrun();
        int edges, drops;
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); @(posedge clk);
        end
        #2 reset = 1'b1;
        #1;
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL midrun_reset_busy: got %b expected 0", busy); end
        assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL midrun_reset_done: got %b expected 0", done); end
        assertCount++; if (quotient !== 32'd0) begin failCount++; $display("[TB] FAIL midrun_reset_quotient: got %0d expected 0", quotient); end
        assertCount++; if (remainder !== 32'd0) begin failCount++; $display("[TB] FAIL midrun_reset_remainder: got %0d expected 0", remainder); end
        @(posedge clk);
        reset = 1'b0;
        @(posedge clk);
        runDiv(32'd50, 32'd6, edges, drops);
        assertCount++; if (edges !== 32) begin failCount++; $display("[TB] FAIL post_reset_latency: got %0d edges expected 32", edges); end
        assertCount++; if (quotient !== 32'd8) begin failCount++; $display("[TB] FAIL post_reset_quotient: got %0d expected 8", quotient); end
        assertCount++; if (remainder !== 32'd2) begin failCount++; $display("[TB] FAIL post_reset_remainder: got %0d expected 2", remainder); end
        toIdle();
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_small();
        test_div_zero();
        test_ignore_start();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
